seg7_scan_counter: RTL and testbench

Parametrised multi-digit BCD seconds counter with a time-multiplexed seven-segment display driver. It generalises the single-digit counter/decoder pair in the user project area to `DIGITS` digits. It adds up/down counting, run/pause, clear, leading-zero blanking and a wrap pulse. It sits between the caravel-style user IOs (clock, control inputs) and the LED segment/digit-select pads.

---
 rtl/seg7_scan_counter.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_counter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter
//   Multi-digit BCD seconds counter with a time-multiplexed seven-segment
//   display driver. A programmable prescaler produces ticks; on each tick
//   the digit chain counts up or down with full same-cycle ripple. A free
//   running scan counter walks the digit enables and the selected digit is
//   decoded to segments, with optional leading-zero blanking.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   period_in    new tick period in clk cycles (0 is treated as 1)
//   period_load  load period_in and restart the prescaler
//   run          1 = count on ticks, 0 = hold digits
//   down         1 = count down, 0 = count up
//   clear        zero the digits and the prescaler
//   blank_lz     blank leading zero digits (digit 0 is never blanked)
//   bcd_out      digit registers, digit 0 in bits [3:0]
//   wrap         one-cycle pulse after the counter wraps
//   seg_out      segments a..g of the selected digit (bit0 = a), active-high
//   dig_sel      one-hot, active-high digit enable
//   io_oeb       output enables, constant all-zero
module seg7_scan_counter #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE_W   = 24,
  parameter int RESET_PERIOD = 16_000_000,
  parameter int SCAN_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] period_in,
  input  logic                  period_load,
  input  logic                  run,
  input  logic                  down,
  input  logic                  clear,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  wrap,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [6+DIGITS:0]     io_oeb
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRESCALE_W-1:0] PONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_presc;
  logic [4*DIGITS-1:0]   r_digits;
  logic                  r_wrap;
  logic [SCAN_W-1:0]     r_scanCnt;
  logic [IDX_W-1:0]      r_scanIdx;

  logic                  w_tick;
  logic [4*DIGITS-1:0]   w_nextDigits;
  logic                  w_rollover;
  logic [3:0]            w_curDigit;
  logic                  w_curBlank;
  logic [6:0]            w_segRaw;

  assign w_tick = (r_presc == r_period - PONE);

  // Next digit values for one count step. A digit only moves when every
  // lower digit rolled over; a carry/borrow out of the top digit means the
  // whole counter wrapped.
  always_comb begin
    logic carry;
    w_nextDigits = r_digits;
    carry        = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (down) begin
          if (r_digits[4*k +: 4] == 4'd0) begin
            w_nextDigits[4*k +: 4] = 4'd9;
          end else begin
            w_nextDigits[4*k +: 4] = r_digits[4*k +: 4] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (r_digits[4*k +: 4] == 4'd9) begin
            w_nextDigits[4*k +: 4] = 4'd0;
          end else begin
            w_nextDigits[4*k +: 4] = r_digits[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    w_rollover = carry;
  end

  // Counter state: clear beats a period load, which beats a tick. A load
  // restarts the prescaler so the first tick lands a full new period later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= PRESCALE_W'(RESET_PERIOD);
      r_presc  <= '0;
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear) begin
        r_digits <= '0;
        r_presc  <= '0;
      end else if (period_load) begin
        r_period <= (period_in == '0) ? PONE : period_in;
        r_presc  <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        if (run) begin
          r_digits <= w_nextDigits;
          r_wrap   <= w_rollover;
        end
      end else begin
        r_presc <= r_presc + PONE;
      end
    end
  end

  // Display scan runs independently of the counter controls so the
  // display keeps refreshing while paused, cleared or reprogrammed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scanCnt <= '0;
      r_scanIdx <= '0;
    end else begin
      r_scanCnt <= r_scanCnt + SCAN_W'(1);
      if (&r_scanCnt) begin
        r_scanIdx <= (r_scanIdx == IDX_W'(DIGITS - 1)) ? '0 : r_scanIdx + IDX_W'(1);
      end
    end
  end

  // Pick the selected digit. Walking from the top digit down tracks whether
  // this digit and everything above it are zero, which is the blanking rule.
  always_comb begin
    logic allZero;
    w_curDigit = r_digits[3:0];
    w_curBlank = 1'b0;
    allZero    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      allZero = allZero && (r_digits[4*k +: 4] == 4'd0);
      if (r_scanIdx == IDX_W'(k)) begin
        w_curDigit = r_digits[4*k +: 4];
        w_curBlank = blank_lz && allZero && (k != 0);
      end
    end
  end

  // Segment patterns, bit0 = a ... bit6 = g.
  always_comb begin
    w_segRaw = 7'b0000000;
    case (w_curDigit)
      4'd0: w_segRaw = 7'b0111111;
      4'd1: w_segRaw = 7'b0000110;
      4'd2: w_segRaw = 7'b1011011;
      4'd3: w_segRaw = 7'b1001111;
      4'd4: w_segRaw = 7'b1100110;
      4'd5: w_segRaw = 7'b1101101;
      4'd6: w_segRaw = 7'b1111101;
      4'd7: w_segRaw = 7'b0000111;
      4'd8: w_segRaw = 7'b1111111;
      4'd9: w_segRaw = 7'b1101111;
      default: w_segRaw = 7'b0000000;
    endcase
  end

  assign seg_out = w_curBlank ? 7'b0000000 : w_segRaw;
  assign dig_sel = DIGITS'(1) << r_scanIdx;
  assign bcd_out = r_digits;
  assign wrap    = r_wrap;
  assign io_oeb  = '0;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb_seg7_scan_counter
//   Self-checking bench for seg7_scan_counter with DIGITS=2,
//   RESET_PERIOD=10, SCAN_W=2. A reference model keeps the count as a plain
//   integer, the prescaler as a phase counter and the scan position as a
//   cycle count since reset; expected digits, segments and enables are
//   derived from those with arithmetic.
module tb_seg7_scan_counter;

  localparam int DIGITS       = 2;
  localparam int PRESCALE_W   = 24;
  localparam int RESET_PERIOD = 10;
  localparam int SCAN_W       = 2;
  localparam int MOD          = 100;
  localparam int DWELL        = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [PRESCALE_W-1:0] period_in = '0;
  logic                  period_load = 1'b0;
  logic                  run = 1'b0;
  logic                  down = 1'b0;
  logic                  clear = 1'b0;
  logic                  blank_lz = 1'b0;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  wrap;
  logic [6:0]            seg_out;
  logic [DIGITS-1:0]     dig_sel;
  logic [6+DIGITS:0]     io_oeb;

  int total = 0;
  int bad   = 0;

  seg7_scan_counter #(
    .DIGITS(DIGITS), .PRESCALE_W(PRESCALE_W),
    .RESET_PERIOD(RESET_PERIOD), .SCAN_W(SCAN_W)
  ) dut (
    .clk(clk), .reset(reset), .period_in(period_in), .period_load(period_load),
    .run(run), .down(down), .clear(clear), .blank_lz(blank_lz),
    .bcd_out(bcd_out), .wrap(wrap), .seg_out(seg_out), .dig_sel(dig_sel),
    .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  // Reference model state
  int mCount  = 0;
  int mPresc  = 0;
  int mPeriod = RESET_PERIOD;
  int mScan   = 0;
  bit mWrap   = 1'b0;

  logic [6:0] segTable [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  // The model advances on the same edge as the DUT using the inputs the
  // DUT sees at that edge.
  always @(posedge clk) begin
    if (reset) begin
      mPeriod <= RESET_PERIOD;
      mPresc  <= 0;
      mCount  <= 0;
      mWrap   <= 1'b0;
      mScan   <= 0;
    end else begin
      mScan <= mScan + 1;
      mWrap <= 1'b0;
      if (clear) begin
        mCount <= 0;
        mPresc <= 0;
      end else if (period_load) begin
        mPeriod <= (period_in == '0) ? 1 : int'(period_in);
        mPresc  <= 0;
      end else if (mPresc == mPeriod - 1) begin
        mPresc <= 0;
        if (run) begin
          if (!down) begin
            mCount <= (mCount + 1) % MOD;
            mWrap  <= (mCount == MOD - 1);
          end else begin
            mCount <= (mCount + MOD - 1) % MOD;
            mWrap  <= (mCount == 0);
          end
        end
      end else begin
        mPresc <= mPresc + 1;
      end
    end
  end

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*DIGITS-1:0] expBcd(int value);
    logic [4*DIGITS-1:0] e = '0;
    for (int k = 0; k < DIGITS; k++) e[4*k +: 4] = 4'((value / pow10(k)) % 10);
    return e;
  endfunction

  function automatic logic [DIGITS-1:0] expSel();
    return DIGITS'(1) << ((mScan / DWELL) % DIGITS);
  endfunction

  function automatic logic [6:0] expSeg(logic blank);
    int k = (mScan / DWELL) % DIGITS;
    int d = (mCount / pow10(k)) % 10;
    if (blank && k >= 1 && mCount < pow10(k)) return 7'b0000000;
    return segTable[d];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count up with period already short until the model reaches target,
  // then pause.
  task automatic runTo(int target);
    bit hit = 1'b0;
    down = 1'b0;
    run  = 1'b1;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (mCount == target) hit = 1'b1;
    end
    run = 1'b0;
    total++;
    if (!hit || bcd_out !== expBcd(target)) begin
      bad++;
      $display("[TB] FAIL runTo: bcd_out=%h required=%h reached=%0d", bcd_out, expBcd(target), hit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; down = 1'b0; clear = 1'b0;
    period_load = 1'b0; blank_lz = 1'b0;
    repeat (3) step();
    total++; if (bcd_out !== 8'h00)      begin bad++; $display("[TB] FAIL reset bcd: got=%h want=00", bcd_out); end
    total++; if (wrap !== 1'b0)          begin bad++; $display("[TB] FAIL reset wrap: got=%b want=0", wrap); end
    total++; if (dig_sel !== 2'b01)      begin bad++; $display("[TB] FAIL reset dig_sel: got=%b want=01", dig_sel); end
    total++; if (seg_out !== 7'b0111111) begin bad++; $display("[TB] FAIL reset seg: got=%b want=0111111", seg_out); end
    total++; if (io_oeb !== '0)          begin bad++; $display("[TB] FAIL reset io_oeb: got=%b want=0", io_oeb); end
  endtask

  task automatic test_count_up();
    logic [7:0] exp;
    reset = 1'b0;
    run   = 1'b1;
    down  = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp = (e >= 20) ? 8'h02 : (e >= 10) ? 8'h01 : 8'h00;
      total++; if (bcd_out !== exp) begin bad++; $display("[TB] FAIL first ticks edge %0d: got=%h want=%h", e, bcd_out, exp); end
      total++; if (io_oeb !== '0)   begin bad++; $display("[TB] FAIL io_oeb edge %0d: got=%b want=0", e, io_oeb); end
    end
  endtask

  task automatic test_wrap();
    period_in = 24'd1; period_load = 1'b1;
    step();
    period_load = 1'b0;
    runTo(99);
    run = 1'b1; step(); run = 1'b0;
    total++; if (bcd_out !== 8'h00) begin bad++; $display("[TB] FAIL wrap up bcd: got=%h want=00", bcd_out); end
    total++; if (wrap !== 1'b1)     begin bad++; $display("[TB] FAIL wrap up pulse: got=%b want=1", wrap); end
    step();
    total++; if (wrap !== 1'b0)     begin bad++; $display("[TB] FAIL wrap up width: got=%b want=0", wrap); end
    down = 1'b1; run = 1'b1; step(); run = 1'b0;
    total++; if (bcd_out !== 8'h99) begin bad++; $display("[TB] FAIL wrap down bcd: got=%h want=99", bcd_out); end
    total++; if (wrap !== 1'b1)     begin bad++; $display("[TB] FAIL wrap down pulse: got=%b want=1", wrap); end
    step();
    total++; if (wrap !== 1'b0)     begin bad++; $display("[TB] FAIL wrap down width: got=%b want=0", wrap); end
    runTo(10);
    down = 1'b1; run = 1'b1; step(); run = 1'b0; down = 1'b0;
    total++; if (bcd_out !== 8'h09) begin bad++; $display("[TB] FAIL borrow 10->09: got=%h want=09", bcd_out); end
    total++; if (wrap !== 1'b0)     begin bad++; $display("[TB] FAIL borrow wrap: got=%b want=0", wrap); end
  endtask

  task automatic test_period_load();
    int start;
    period_in = 24'd10; period_load = 1'b1;
    step();
    period_load = 1'b0; run = 1'b1; down = 1'b0;
    repeat (4) step();
    start = mCount;
    period_in = 24'd3; period_load = 1'b1;
    step();
    period_load = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      step();
      total++;
      if (bcd_out !== expBcd((start + j / 3) % MOD)) begin
        bad++; $display("[TB] FAIL period3 edge %0d: got=%h want=%h", j, bcd_out, expBcd((start + j / 3) % MOD));
      end
    end
    period_in = 24'd0; period_load = 1'b1;
    start = mCount;
    step();
    period_load = 1'b0;
    total++; if (bcd_out !== expBcd(start)) begin bad++; $display("[TB] FAIL load-edge tick: got=%h want=%h", bcd_out, expBcd(start)); end
    for (int j = 1; j <= 5; j++) begin
      step();
      total++;
      if (bcd_out !== expBcd((start + j) % MOD)) begin
        bad++; $display("[TB] FAIL period0 edge %0d: got=%h want=%h", j, bcd_out, expBcd((start + j) % MOD));
      end
    end
  endtask

  task automatic test_run_hold();
    int hold;
    run  = 1'b0;
    hold = mCount;
    for (int i = 0; i < 25; i++) begin
      step();
      total++; if (bcd_out !== expBcd(hold)) begin bad++; $display("[TB] FAIL hold bcd cyc %0d: got=%h want=%h", i, bcd_out, expBcd(hold)); end
      total++; if (wrap !== 1'b0)            begin bad++; $display("[TB] FAIL hold wrap cyc %0d: got=%b want=0", i, wrap); end
    end
  endtask

  task automatic test_clear_on_tick();
    runTo(99);
    run = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; run = 1'b0;
    total++; if (bcd_out !== 8'h00) begin bad++; $display("[TB] FAIL clear bcd: got=%h want=00", bcd_out); end
    total++; if (wrap !== 1'b0)     begin bad++; $display("[TB] FAIL clear wrap: got=%b want=0", wrap); end
    step();
    total++; if (wrap !== 1'b0)     begin bad++; $display("[TB] FAIL clear late wrap: got=%b want=0", wrap); end
  endtask

  task automatic test_scan();
    logic [1:0] prevSel;
    logic [6:0] expS;
    int         runLen;
    int         changes;
    runTo(7);
    run = 1'b0;
    changes = 0;
    runLen  = 0;
    prevSel = dig_sel;
    for (int i = 0; i < 32; i++) begin
      blank_lz = (i >= 16);
      step();
      total++; if (dig_sel !== expSel()) begin bad++; $display("[TB] FAIL scan sel cyc %0d: got=%b want=%b", i, dig_sel, expSel()); end
      expS = (expSel() == 2'b01) ? 7'b0000111 : (blank_lz ? 7'b0000000 : 7'b0111111);
      total++; if (seg_out !== expS) begin bad++; $display("[TB] FAIL scan seg cyc %0d: got=%b want=%b", i, seg_out, expS); end
      runLen++;
      if (dig_sel !== prevSel) begin
        if (changes > 0) begin
          total++; if (runLen !== DWELL) begin bad++; $display("[TB] FAIL scan dwell: got=%0d want=%0d", runLen, DWELL); end
        end
        changes++;
        runLen  = 0;
        prevSel = dig_sel;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      reset       = ($urandom_range(0, 149) == 0);
      run         = ($urandom_range(0, 3) != 0);
      down        = 1'($urandom_range(0, 1));
      clear       = ($urandom_range(0, 49) == 0);
      period_load = ($urandom_range(0, 19) == 0);
      period_in   = PRESCALE_W'($urandom_range(0, 4));
      blank_lz    = 1'($urandom_range(0, 1));
      step();
      total++; if (bcd_out !== expBcd(mCount))    begin bad++; $display("[TB] FAIL rnd bcd %0d: got=%h want=%h", i, bcd_out, expBcd(mCount)); end
      total++; if (wrap !== mWrap)                begin bad++; $display("[TB] FAIL rnd wrap %0d: got=%b want=%b", i, wrap, mWrap); end
      total++; if (dig_sel !== expSel())          begin bad++; $display("[TB] FAIL rnd sel %0d: got=%b want=%b", i, dig_sel, expSel()); end
      total++; if (seg_out !== expSeg(blank_lz))  begin bad++; $display("[TB] FAIL rnd seg %0d: got=%b want=%b", i, seg_out, expSeg(blank_lz)); end
      total++; if (io_oeb !== '0)                 begin bad++; $display("[TB] FAIL rnd io_oeb %0d: got=%b want=0", i, io_oeb); end
    end
    reset = 1'b0; clear = 1'b0; period_load = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_period_load();
    test_run_hold();
    test_clear_on_tick();
    test_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
